pc_unit: RTL

Registered 10-bit program-counter stage of the CPU fetch path. Each enabled cycle it selects the next instruction address (increment, absolute jump, conditional relative branch, call, return) and drives the instruction-memory address plus the 10-bit address/PC register downstream. It holds a small hardware return-address stack for CALL/RET, with sticky overflow and underflow flags.

---
 rtl/pc_unit_pkg.sv | 19 +
 rtl/pc_unit_return_stack.sv | 51 +++++
 rtl/pc_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage: next-PC select codes and the address width.
`default_nettype none

package pc_unit_pkg;

  localparam int PC_ADDR_W = 10;
  localparam int PC_OFF_W  = 8;

  typedef enum logic [2:0] {
    PC_INC  = 3'b000,
    PC_JMP  = 3'b001,
    PC_BR   = 3'b010,
    PC_CALL = 3'b011,
    PC_RET  = 3'b100
  } pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_unit_return_stack.sv
// Return-address LIFO. Pushes when full and pops when empty are ignored; popped
// storage is left intact, so only count defines which entries are valid.
`default_nettype none

module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;

  // DEPTH is a power of two, so the low count bits index the next free slot
  // and wrap to DEPTH-1 for the top when the stack is full.
  assign wr_ptr  = count[PTR_W-1:0];
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      mem[wr_ptr] <= din;
      count       <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// Registered program counter with next-PC select (INC/JMP/BR/CALL/RET), a
// hardware return-address stack and sticky overflow/underflow flags.
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                ADDR_W      = PC_ADDR_W,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   sel,
  input  logic                         cond,
  input  logic [ADDR_W-1:0]            target,
  input  logic [PC_OFF_W-1:0]          offset,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_next,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] br_dest;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              is_call;
  logic              is_ret;
  logic              push;
  logic              pop;

  assign inc     = pc + ADDR_W'(1);
  assign br_dest = inc + {{(ADDR_W-PC_OFF_W){offset[PC_OFF_W-1]}}, offset};
  assign is_call = (sel == PC_CALL);
  assign is_ret  = (sel == PC_RET);
  assign push    = en && is_call && !stk_full;
  assign pop     = en && is_ret && !stk_empty;

  always_comb begin
    pc_next = inc;
    case (sel)
      PC_JMP:  pc_next = target;
      PC_BR:   pc_next = cond ? br_dest : inc;
      PC_CALL: pc_next = target;
      PC_RET:  pc_next = stk_empty ? inc : stk_top;
      default: pc_next = inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc              <= RESET_PC;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (is_call && stk_full) begin
        stack_overflow <= 1'b1;
      end
      if (is_ret && stk_empty) begin
        stack_underflow <= 1'b1;
      end
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_return_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (stk_top),
    .count (sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule

`default_nettype wire
